mixer_fade_ctrl: RTL and testbench

Sequencing controller for the effects mixer. It owns the mixer's `effects_sel` input and applies a gain ramp to the mixer's output sample. An effect change request ramps the gain down to zero, switches `effects_sel`, waits for the effect pipelines to settle, then ramps the gain back to unity. This removes clicks on effect switching. It sits between the effects register/wishbone slave and the DAC path.

---
 rtl/mixer_fade_ctrl.sv | 130 +++++++++++++
 tb/tb_mixer_fade_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mixer_fade_ctrl.sv
// Click-free effect switching: ramps mixer gain to zero, swaps effects_sel, settles, ramps back to unity.
// audio_out is 1 clk after sample_en; req_ready is low (request held off, not latched) outside IDLE.
module mixer_fade_ctrl #(
  parameter logic [7:0] ZERO_LVL     = 8'h80,
  parameter logic [8:0] STEP         = 9'd16,
  parameter logic [7:0] HOLD_SAMPLES = 8'd4,
  parameter logic [2:0] INIT_SEL     = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [7:0] mix_in,
  input  logic       req_valid,
  input  logic [2:0] req_sel,
  output logic       req_ready,
  output logic [2:0] effects_sel,
  output logic [7:0] audio_out,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, FADE_OUT, SWITCH, SETTLE, FADE_IN} state_t;

  state_t      r_state;
  logic [8:0]  r_gain;
  logic [2:0]  r_sel;
  logic [2:0]  r_pend;
  logic [7:0]  r_hold;
  logic [7:0]  r_audio;
  logic        r_busy;
  logic        r_ready;

  logic signed [19:0] w_d;
  logic signed [19:0] w_g;
  logic signed [19:0] w_p;
  logic signed [19:0] w_q;
  logic signed [11:0] w_sum;
  logic [7:0]         w_sat;
  logic [8:0]         w_gain_dn;
  logic [9:0]         w_up_sum;
  logic [8:0]         w_gain_up;

  // Offset-binary sample re-centred to signed, scaled by gain/256, re-offset and clamped.
  assign w_d   = $signed({12'd0, mix_in}) - $signed({12'd0, ZERO_LVL});
  assign w_g   = $signed({11'd0, r_gain});
  assign w_p   = w_d * w_g;
  assign w_q   = w_p >>> 8;
  assign w_sum = $signed({4'd0, ZERO_LVL}) + $signed(w_q[11:0]);

  always_comb begin
    w_sat = w_sum[7:0];
    if (w_sum < 0)
      w_sat = 8'h00;
    else if (w_sum > 12'sd255)
      w_sat = 8'hFF;
  end

  assign w_gain_dn = (r_gain > STEP) ? (r_gain - STEP) : 9'd0;
  assign w_up_sum  = {1'b0, r_gain} + {1'b0, STEP};
  assign w_gain_up = (w_up_sum >= 10'd256) ? 9'd256 : w_up_sum[8:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gain  <= 9'd256;
      r_sel   <= INIT_SEL;
      r_pend  <= INIT_SEL;
      r_hold  <= 8'd0;
      r_audio <= ZERO_LVL;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      // Output always uses the gain from before this strobe's ramp step.
      if (sample_en)
        r_audio <= w_sat;

      case (r_state)
        IDLE: begin
          r_gain <= 9'd256;
          if (req_valid && (req_sel != r_sel)) begin
            r_pend  <= req_sel;
            r_state <= FADE_OUT;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        FADE_OUT: begin
          if (sample_en) begin
            r_gain <= w_gain_dn;
            if (w_gain_dn == 9'd0)
              r_state <= SWITCH;
          end
        end
        SWITCH: begin
          r_sel  <= r_pend;
          r_hold <= HOLD_SAMPLES;
          r_state <= (HOLD_SAMPLES == 8'd0) ? FADE_IN : SETTLE;
        end
        SETTLE: begin
          r_gain <= 9'd0;
          if (sample_en) begin
            r_hold <= r_hold - 8'd1;
            if (r_hold == 8'd1)
              r_state <= FADE_IN;
          end
        end
        FADE_IN: begin
          if (sample_en) begin
            r_gain <= w_gain_up;
            if (w_gain_up == 9'd256) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign effects_sel = r_sel;
  assign audio_out   = r_audio;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mixer_fade_ctrl.sv
// Bench for mixer_fade_ctrl: three parameterisations, audio checked through per-instance expected queues.
module tb_mixer_fade_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] se;
  logic [2:0] rv;
  logic [7:0] mix [3];
  logic [2:0] rs  [3];
  logic [2:0] rdy;
  logic [2:0] bsy;
  logic [2:0] sel [3];
  logic [7:0] aud [3];

  logic [7:0] exp_q [3][$];
  logic [2:0] se_d;
  logic [7:0] mon_e;
  int n_chk  = 0;
  int n_fail = 0;

  mixer_fade_ctrl #(.ZERO_LVL(8'h80), .STEP(9'd16), .HOLD_SAMPLES(8'd4), .INIT_SEL(3'b001)) u_main (
    .clk(clk), .reset(reset), .sample_en(se[0]), .mix_in(mix[0]), .req_valid(rv[0]), .req_sel(rs[0]),
    .req_ready(rdy[0]), .effects_sel(sel[0]), .audio_out(aud[0]), .busy(bsy[0]));

  mixer_fade_ctrl #(.ZERO_LVL(8'h10), .STEP(9'd128), .HOLD_SAMPLES(8'd0), .INIT_SEL(3'b001)) u_z (
    .clk(clk), .reset(reset), .sample_en(se[1]), .mix_in(mix[1]), .req_valid(rv[1]), .req_sel(rs[1]),
    .req_ready(rdy[1]), .effects_sel(sel[1]), .audio_out(aud[1]), .busy(bsy[1]));

  mixer_fade_ctrl #(.ZERO_LVL(8'h10), .STEP(9'd256), .HOLD_SAMPLES(8'd0), .INIT_SEL(3'b001)) u_s (
    .clk(clk), .reset(reset), .sample_en(se[2]), .mix_in(mix[2]), .req_valid(rv[2]), .req_sel(rs[2]),
    .req_ready(rdy[2]), .effects_sel(sel[2]), .audio_out(aud[2]), .busy(bsy[2]));

  always @(posedge clk) se_d <= se;

  // Every strobe must produce exactly one queued expectation, compared mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (se_d[i]) begin
        n_chk++;
        if (exp_q[i].size() == 0) begin
          n_fail++;
          $display("FAIL audio%0d: got %02h with no expected value queued", i, aud[i]);
        end else begin
          mon_e = exp_q[i].pop_front();
          if (aud[i] !== mon_e) begin
            n_fail++;
            $display("FAIL audio%0d: got %02h, expected %02h", i, aud[i], mon_e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input logic [7:0] m, input logic [7:0] e);
    exp_q[i].push_back(e);
    mix[i] = m;
    se[i]  = 1'b1;
    tick();
    se[i]  = 1'b0;
    tick();
  endtask

  task automatic req(input int i, input logic [2:0] s);
    rv[i] = 1'b1;
    rs[i] = s;
    tick();
    rv[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    se    = '0;
    rv    = '0;
    for (int i = 0; i < 3; i++) begin
      mix[i] = 8'h00;
      rs[i]  = 3'b000;
    end
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_sel",   int'(sel[0]), 1);
    chk("rst_audio", int'(aud[0]), 'h80);
    chk("rst_ready", int'(rdy[0]), 1);
    chk("rst_busy",  int'(bsy[0]), 0);
    chk("rst_audio_z", int'(aud[1]), 'h10);

    // Unity pass-through, then hold without strobes
    strobe(0, 8'hC0, 8'hC0);
    mix[0] = 8'h00;
    tick(); tick(); tick();
    chk("hold_audio", int'(aud[0]), 'hC0);
    mix[0] = 8'hC0;

    // Full switch to 3'b010: fade-out, switch, settle, fade-in
    req(0, 3'b010);
    chk("fo_busy",  int'(bsy[0]), 1);
    chk("fo_ready", int'(rdy[0]), 0);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) chk("sel_before_zero", int'(sel[0]), 1);
      strobe(0, 8'hC0, 8'(192 - 4 * (k - 1)));
    end
    chk("sel_switched", int'(sel[0]), 2);
    for (int k = 0; k < 4; k++) strobe(0, 8'hC0, 8'h80);
    for (int j = 1; j <= 16; j++) begin
      if (j == 16) chk("fi_busy_last", int'(bsy[0]), 1);
      strobe(0, 8'hC0, 8'(128 + 4 * (j - 1)));
    end
    chk("fi_done_busy",  int'(bsy[0]), 0);
    chk("fi_done_ready", int'(rdy[0]), 1);
    strobe(0, 8'hC0, 8'hC0);

    // Request for the already-selected effect
    req(0, 3'b010);
    chk("same_busy",  int'(bsy[0]), 0);
    chk("same_ready", int'(rdy[0]), 1);
    chk("same_audio", int'(aud[0]), 'hC0);
    chk("same_sel",   int'(sel[0]), 2);

    // Switch to 3'b100 with a competing request held during fade-out, then reset mid fade-in
    req(0, 3'b100);
    for (int k = 1; k <= 3; k++) strobe(0, 8'hC0, 8'(192 - 4 * (k - 1)));
    rv[0] = 1'b1;
    rs[0] = 3'b010;
    for (int k = 4; k <= 16; k++) begin
      if (k == 4 || k == 15) chk("midfade_ready", int'(rdy[0]), 0);
      strobe(0, 8'hC0, 8'(192 - 4 * (k - 1)));
    end
    rv[0] = 1'b0;
    chk("ignored_req_sel", int'(sel[0]), 4);
    for (int k = 0; k < 4; k++) strobe(0, 8'hC0, 8'h80);
    strobe(0, 8'hC0, 8'h80);
    strobe(0, 8'hC0, 8'h84);
    chk("pre_rst_busy", int'(bsy[0]), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy",  int'(bsy[0]), 0);
    chk("midrst_ready", int'(rdy[0]), 1);
    chk("midrst_sel",   int'(sel[0]), 1);
    chk("midrst_audio", int'(aud[0]), 'h80);
    strobe(0, 8'hC0, 8'hC0);

    // ZERO_LVL=0x10, STEP=128, no hold
    chk("z_rst_audio", int'(aud[1]), 'h10);
    strobe(1, 8'hFF, 8'hFF);
    req(1, 3'b010);
    strobe(1, 8'h00, 8'h00);
    strobe(1, 8'h00, 8'h08);
    chk("z_sel",  int'(sel[1]), 2);
    chk("z_busy", int'(bsy[1]), 1);
    strobe(1, 8'h00, 8'h10);
    strobe(1, 8'h00, 8'h08);
    chk("z_done_busy", int'(bsy[1]), 0);

    // ZERO_LVL=0x10, STEP=256: one strobe each way
    req(2, 3'b101);
    chk("s_busy", int'(bsy[2]), 1);
    strobe(2, 8'hFF, 8'hFF);
    chk("s_sel",       int'(sel[2]), 5);
    chk("s_busy_mid",  int'(bsy[2]), 1);
    strobe(2, 8'hFF, 8'h10);
    chk("s_done_busy",  int'(bsy[2]), 0);
    chk("s_done_ready", int'(rdy[2]), 1);
    strobe(2, 8'hFF, 8'hFF);

    tick();
    tick();
    for (int i = 0; i < 3; i++) chk("queue_drained", exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
